// File: rtl/id_exe_fwd_stage_pkg.sv
// Shared constants and the ID/EXE pipeline bundle for the operand-forwarding stage.
package id_exe_fwd_stage_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned RADDR_D = 5;
  localparam int unsigned CTRLW_D = 8;

  // Register 0 reads as zero and is never a forwarding target.
  localparam logic [RADDR_D-1:0] REG_ZERO = '0;

  // ID/EXE bundle; sized by the package defaults, so stage width overrides must match these.
  typedef struct packed {
    logic [XLEN_D-1:0]  pc4;
    logic [XLEN_D-1:0]  a;
    logic [XLEN_D-1:0]  b;
    logic [XLEN_D-1:0]  imm;
    logic [RADDR_D-1:0] rn;
    logic               wreg;
    logic               m2reg;
    logic [CTRLW_D-1:0] ctrl;
    logic               valid;
  } id_ex_t;

endpackage

// File: rtl/id_exe_fwd_stage_if.sv
// Decode-side and pipeline-side signals of the ID/EXE forwarding stage.
interface id_exe_fwd_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CTRLW = 8,
  parameter int unsigned CNTW  = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc4;
  logic [XLEN-1:0]  id_imm;
  logic [RADDR-1:0] id_rs;
  logic [RADDR-1:0] id_rt;
  logic [RADDR-1:0] id_rn;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [CTRLW-1:0] id_ctrl;
  logic [XLEN-1:0]  id_qa;
  logic [XLEN-1:0]  id_qb;
  logic [XLEN-1:0]  exe_alu;
  logic [RADDR-1:0] mem_rn;
  logic             mem_wreg;
  logic             mem_m2reg;
  logic [XLEN-1:0]  mem_alu;
  logic [XLEN-1:0]  mem_mdo;
  logic             flush;

  logic             stall_en;
  logic [XLEN-1:0]  id_a;
  logic [XLEN-1:0]  id_b;
  logic             ex_valid;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [XLEN-1:0]  ex_pc4;
  logic [XLEN-1:0]  ex_a;
  logic [XLEN-1:0]  ex_b;
  logic [XLEN-1:0]  ex_imm;
  logic [RADDR-1:0] ex_rn;
  logic [CTRLW-1:0] ex_ctrl;
  logic [CNTW-1:0]  stall_cnt;

  modport master (
    output id_valid, id_pc4, id_imm, id_rs, id_rt, id_rn, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_ctrl, id_qa, id_qb, exe_alu, mem_rn, mem_wreg,
           mem_m2reg, mem_alu, mem_mdo, flush,
    input  stall_en, id_a, id_b, ex_valid, ex_wreg, ex_m2reg, ex_pc4, ex_a, ex_b,
           ex_imm, ex_rn, ex_ctrl, stall_cnt
  );

  modport slave (
    input  id_valid, id_pc4, id_imm, id_rs, id_rt, id_rn, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_ctrl, id_qa, id_qb, exe_alu, mem_rn, mem_wreg,
           mem_m2reg, mem_alu, mem_mdo, flush,
    output stall_en, id_a, id_b, ex_valid, ex_wreg, ex_m2reg, ex_pc4, ex_a, ex_b,
           ex_imm, ex_rn, ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_exe_fwd_stage_operand_fwd_mux.sv
// Per-operand EXE/MEM hit detection and forwarding select.
module operand_fwd_mux import id_exe_fwd_stage_pkg::*; #(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned RADDR  = RADDR_D,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [RADDR-1:0] src,
  input  logic [XLEN-1:0]  raw,
  input  logic             ex_valid,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [RADDR-1:0] ex_rn,
  input  logic [XLEN-1:0]  exe_alu,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [RADDR-1:0] mem_rn,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic [XLEN-1:0]  mem_mdo,
  output logic             hit_e_c,
  output logic             hit_m_c,
  output logic [XLEN-1:0]  opnd_c
);

  // Hits never fire on register 0; EXE wins over MEM, a load still in EXE cannot forward.
  always_comb begin
    hit_e_c = ex_valid & ex_wreg & (ex_rn == src) & (src != RADDR'(REG_ZERO));
    hit_m_c = mem_wreg & (mem_rn == src) & (src != RADDR'(REG_ZERO));
    opnd_c  = raw;
    if (FWD_EN) begin
      if (hit_e_c & ~ex_m2reg) opnd_c = exe_alu;
      else if (hit_m_c)        opnd_c = mem_m2reg ? mem_mdo : mem_alu;
    end
  end

endmodule

// File: rtl/id_exe_fwd_stage.sv
// ID/EXE stage: operand forwarding, RAW hazard stall, pipeline register and stall counter.
module id_exe_fwd_stage import id_exe_fwd_stage_pkg::*; #(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned RADDR  = RADDR_D,
  parameter int unsigned CTRLW  = CTRLW_D,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNTW   = 16
) (
  input  logic              clk,
  input  logic              clrn,
  id_exe_fwd_stage_if.slave bus
);

  id_ex_t          ex_q, ex_d;
  logic [CNTW-1:0] cnt_q;
  logic            hit_e_a, hit_m_a, hit_e_b, hit_m_b;
  logic [XLEN-1:0] a_c, b_c;
  logic            hazard_c, stall_c;

  operand_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR), .FWD_EN(FWD_EN)) u_fwd_a (
    .src(bus.id_rs), .raw(bus.id_qa),
    .ex_valid(ex_q.valid), .ex_wreg(ex_q.wreg), .ex_m2reg(ex_q.m2reg),
    .ex_rn(RADDR'(ex_q.rn)), .exe_alu(bus.exe_alu),
    .mem_wreg(bus.mem_wreg), .mem_m2reg(bus.mem_m2reg), .mem_rn(bus.mem_rn),
    .mem_alu(bus.mem_alu), .mem_mdo(bus.mem_mdo),
    .hit_e_c(hit_e_a), .hit_m_c(hit_m_a), .opnd_c(a_c)
  );

  operand_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR), .FWD_EN(FWD_EN)) u_fwd_b (
    .src(bus.id_rt), .raw(bus.id_qb),
    .ex_valid(ex_q.valid), .ex_wreg(ex_q.wreg), .ex_m2reg(ex_q.m2reg),
    .ex_rn(RADDR'(ex_q.rn)), .exe_alu(bus.exe_alu),
    .mem_wreg(bus.mem_wreg), .mem_m2reg(bus.mem_m2reg), .mem_rn(bus.mem_rn),
    .mem_alu(bus.mem_alu), .mem_mdo(bus.mem_mdo),
    .hit_e_c(hit_e_b), .hit_m_c(hit_m_b), .opnd_c(b_c)
  );

  // Load-use only when forwarding; any in-flight producer of a used source otherwise.
  always_comb begin
    hazard_c = 1'b0;
    if (FWD_EN) begin
      hazard_c = ((bus.id_use_rs & hit_e_a) | (bus.id_use_rt & hit_e_b)) & ex_q.m2reg;
    end else begin
      hazard_c = (bus.id_use_rs & (hit_e_a | hit_m_a)) |
                 (bus.id_use_rt & (hit_e_b | hit_m_b));
    end
    stall_c = bus.id_valid & hazard_c & ~bus.flush;
  end

  // Next bundle: data always follows ID, control is zeroed for a flush or stall bubble.
  always_comb begin
    ex_d       = '0;
    ex_d.pc4   = XLEN_D'(bus.id_pc4);
    ex_d.a     = XLEN_D'(a_c);
    ex_d.b     = XLEN_D'(b_c);
    ex_d.imm   = XLEN_D'(bus.id_imm);
    ex_d.rn    = RADDR_D'(bus.id_rn);
    if (!(bus.flush | stall_c)) begin
      ex_d.valid = bus.id_valid;
      ex_d.wreg  = bus.id_valid & bus.id_wreg;
      ex_d.m2reg = bus.id_valid & bus.id_m2reg;
      ex_d.ctrl  = CTRLW_D'(bus.id_ctrl);
    end
  end

  // ID/EXE register and saturating stall counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (stall_c && !(&cnt_q)) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.stall_en  = stall_c;
  assign bus.id_a      = a_c;
  assign bus.id_b      = b_c;
  assign bus.ex_valid  = ex_q.valid;
  assign bus.ex_wreg   = ex_q.wreg;
  assign bus.ex_m2reg  = ex_q.m2reg;
  assign bus.ex_pc4    = XLEN'(ex_q.pc4);
  assign bus.ex_a      = XLEN'(ex_q.a);
  assign bus.ex_b      = XLEN'(ex_q.b);
  assign bus.ex_imm    = XLEN'(ex_q.imm);
  assign bus.ex_rn     = RADDR'(ex_q.rn);
  assign bus.ex_ctrl   = CTRLW'(ex_q.ctrl);
  assign bus.stall_cnt = cnt_q;

endmodule
